// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU load/store port between initiator and memory responder
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_wen;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   // CPU side: issues requests and consumes responses
   modport master (
      output req_valid, req_addr, req_size, req_wen, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   // Memory side: accepts requests and produces responses
   modport slave (
      input  req_valid, req_addr, req_size, req_wen, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte-addressed little-endian data memory with fixed programmable latency
module data_mem_responder #(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 2
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave mem_if
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_err_q, resp_err_d;

   logic [7:0]  mem_q [0:(1 << ADDR_WIDTH) - 1];

   logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
   logic                  accept;
   logic                  size_err;
   logic [3:0]            byte_we;
   logic [31:0]           load_data;
   logic                  unused_addr_hi;

   // Upper address bits are simply dropped; accesses wrap within the array.
   assign a0 = mem_if.req_addr[ADDR_WIDTH-1:0];
   assign a1 = a0 + ADDR_WIDTH'(1);
   assign a2 = a0 + ADDR_WIDTH'(2);
   assign a3 = a0 + ADDR_WIDTH'(3);
   assign unused_addr_hi = ^mem_if.req_addr[31:ADDR_WIDTH];

   assign accept = (state_q == IDLE) && mem_if.req_valid;

   // Invalid size or misalignment for the requested width.
   assign size_err = (mem_if.req_size == 2'b11)
                  || ((mem_if.req_size == 2'b01) && mem_if.req_addr[0])
                  || ((mem_if.req_size == 2'b10) && (mem_if.req_addr[1:0] != 2'b00));

   // Byte write enables for a clean store at the accept edge; reset suppresses the write.
   always_comb begin
      byte_we = 4'b0000;
      if (accept && !mem_if.req_wen && !size_err && !rst) begin
         case (mem_if.req_size)
            2'b00:   byte_we = 4'b0001;
            2'b01:   byte_we = 4'b0011;
            2'b10:   byte_we = 4'b1111;
            default: byte_we = 4'b0000;
         endcase
      end
   end

   // Memory array update; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (byte_we[0]) mem_q[a0] <= mem_if.req_wdata[7:0];
      if (byte_we[1]) mem_q[a1] <= mem_if.req_wdata[15:8];
      if (byte_we[2]) mem_q[a2] <= mem_if.req_wdata[23:16];
      if (byte_we[3]) mem_q[a3] <= mem_if.req_wdata[31:24];
   end

   // Raw right-aligned, zero-filled read data for the addressed width.
   always_comb begin
      load_data = 32'h0;
      case (mem_if.req_size)
         2'b00:   load_data = {24'h0, mem_q[a0]};
         2'b01:   load_data = {16'h0, mem_q[a1], mem_q[a0]};
         2'b10:   load_data = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
         default: load_data = 32'h0;
      endcase
   end

   // Control and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         resp_data_q <= 32'h0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Next state: capture the response at accept, count down, then hold until taken.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         IDLE: begin
            if (mem_if.req_valid) begin
               resp_err_d  = size_err;
               resp_data_d = (size_err || !mem_if.req_wen) ? 32'h0 : load_data;
               if (LATENCY > 1) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = RESP;
                  cnt_d   = 4'd0;
               end
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (mem_if.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign mem_if.req_ready  = (state_q == IDLE);
   assign mem_if.resp_valid = (state_q == RESP);
   assign mem_if.resp_data  = resp_data_q;
   assign mem_if.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   data_mem_responder_if aif ();
   data_mem_responder_if bif ();

   data_mem_responder #(.ADDR_WIDTH(16), .LATENCY(2)) dut_a (
      .clk    (clk),
      .rst    (rst),
      .mem_if (aif.slave)
   );

   data_mem_responder #(.ADDR_WIDTH(16), .LATENCY(1)) dut_b (
      .clk    (clk),
      .rst    (rst),
      .mem_if (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_req(input bit b, input logic [31:0] addr, input logic [1:0] size,
                         input logic wen, input logic [31:0] wdata,
                         output logic [31:0] data, output logic err, output int lat);
      logic v;
      @(negedge clk);
      if (b) begin
         bif.req_valid = 1'b1; bif.req_addr = addr; bif.req_size = size;
         bif.req_wen = wen; bif.req_wdata = wdata;
      end else begin
         aif.req_valid = 1'b1; aif.req_addr = addr; aif.req_size = size;
         aif.req_wen = wen; aif.req_wdata = wdata;
      end
      @(posedge clk);
      @(negedge clk);
      if (b) bif.req_valid = 1'b0;
      else   aif.req_valid = 1'b0;
      lat = 1;
      v = b ? bif.resp_valid : aif.resp_valid;
      while (!v && lat < 40) begin
         @(negedge clk);
         lat++;
         v = b ? bif.resp_valid : aif.resp_valid;
      end
      if (!v) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout addr=%h got no resp_valid within %0d cycles", addr, lat);
      end
      data = b ? bif.resp_data : aif.resp_data;
      err  = b ? bif.resp_err : aif.resp_err;
      if (b) bif.resp_ready = 1'b1;
      else   aif.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (b) bif.resp_ready = 1'b0;
      else   aif.resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      checks++; if (aif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", aif.req_ready); end
      checks++; if (aif.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", aif.resp_valid); end
      checks++; if (aif.resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h exp 0", aif.resp_data); end
      checks++; if (aif.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b exp 0", aif.resp_err); end
      checks++; if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready got %b exp 1", bif.req_ready); end
   endtask

   task automatic test_word_store_load;
      logic [31:0] d; logic e; int lat;
      do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, d, e, lat);
      checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL store_resp got d=%h e=%b exp d=0 e=0", d, e); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d exp 2", lat); end
      do_req(1'b0, 32'h100, 2'b10, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load got %h exp deadbeef", d); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_load_err got %b exp 0", e); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d exp 2", lat); end
      do_req(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'h000000DE) begin errors++; $display("FAIL byte_load got %h exp 000000de", d); end
      do_req(1'b0, 32'h102, 2'b01, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'h0000DEAD) begin errors++; $display("FAIL half_load got %h exp 0000dead", d); end
   endtask

   task automatic test_partial_merge;
      logic [31:0] d; logic e; int lat;
      do_req(1'b0, 32'h200, 2'b10, 1'b0, 32'h11223344, d, e, lat);
      do_req(1'b0, 32'h201, 2'b00, 1'b0, 32'hFFFFFFAA, d, e, lat);
      do_req(1'b0, 32'h202, 2'b01, 1'b0, 32'hFFFFBBCC, d, e, lat);
      do_req(1'b0, 32'h200, 2'b10, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'hBBCCAA44) begin errors++; $display("FAIL merge_load got %h exp bbccaa44", d); end
   endtask

   task automatic test_errors;
      logic [31:0] d; logic e; int lat;
      do_req(1'b0, 32'h300, 2'b10, 1'b0, 32'h55667788, d, e, lat);
      do_req(1'b0, 32'h301, 2'b01, 1'b1, 32'h0, d, e, lat);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL misaligned_half got e=%b d=%h exp e=1 d=0", e, d); end
      do_req(1'b0, 32'h302, 2'b10, 1'b0, 32'hA5A5A5A5, d, e, lat);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_word_store got e=%b exp 1", e); end
      do_req(1'b0, 32'h300, 2'b10, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'h55667788 || e !== 1'b0) begin errors++; $display("FAIL untouched_after_err got d=%h e=%b exp 55667788 0", d, e); end
      do_req(1'b0, 32'h300, 2'b11, 1'b1, 32'h0, d, e, lat);
      checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL invalid_size got e=%b d=%h exp e=1 d=0", e, d); end
   endtask

   task automatic test_backpressure;
      logic [31:0] d0; logic e0; int lat;
      @(negedge clk);
      aif.req_valid = 1'b1; aif.req_addr = 32'h100; aif.req_size = 2'b10; aif.req_wen = 1'b1;
      @(posedge clk);
      @(negedge clk);
      aif.req_valid = 1'b0;
      lat = 1;
      while (!aif.resp_valid && lat < 40) begin @(negedge clk); lat++; end
      d0 = aif.resp_data; e0 = aif.resp_err;
      checks++; if (d0 !== 32'hDEADBEEF || e0 !== 1'b0) begin errors++; $display("FAIL bp_first got d=%h e=%b exp deadbeef 0", d0, e0); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (aif.resp_valid !== 1'b1 || aif.resp_data !== 32'hDEADBEEF || aif.resp_err !== 1'b0 || aif.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b rdy=%b exp 1 deadbeef 0 0", i, aif.resp_valid, aif.resp_data, aif.resp_err, aif.req_ready);
         end
      end
      aif.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      aif.resp_ready = 1'b0;
      checks++; if (aif.req_ready !== 1'b1 || aif.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b v=%b exp 1 0", aif.req_ready, aif.resp_valid); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; logic e; int lat;
      @(negedge clk);
      aif.req_valid = 1'b1; aif.req_addr = 32'h400; aif.req_size = 2'b10;
      aif.req_wen = 1'b0; aif.req_wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      aif.req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (aif.resp_valid !== 1'b0 || aif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset cyc=%0d got v=%b rdy=%b exp 0 1", i, aif.resp_valid, aif.req_ready);
         end
         @(negedge clk);
      end
      do_req(1'b0, 32'h400, 2'b10, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL store_survives_reset got %h exp 12345678", d); end
   endtask

   task automatic test_reset_priority;
      logic [31:0] d; logic e; int lat;
      do_req(1'b0, 32'h500, 2'b10, 1'b0, 32'h01020304, d, e, lat);
      @(negedge clk);
      aif.req_valid = 1'b1; aif.req_addr = 32'h500; aif.req_size = 2'b10;
      aif.req_wen = 1'b0; aif.req_wdata = 32'hFFFFFFFF;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      aif.req_valid = 1'b0;
      rst = 1'b0;
      checks++; if (aif.req_ready !== 1'b1 || aif.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_prio_state got rdy=%b v=%b exp 1 0", aif.req_ready, aif.resp_valid); end
      do_req(1'b0, 32'h500, 2'b10, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'h01020304) begin errors++; $display("FAIL rst_prio_nowrite got %h exp 01020304", d); end
   endtask

   task automatic test_latency1_wrap;
      logic [31:0] d; logic e; int lat;
      do_req(1'b1, 32'h00010010, 2'b10, 1'b0, 32'hCAFEF00D, d, e, lat);
      checks++; if (e !== 1'b0 || lat !== 1) begin errors++; $display("FAIL l1_store got e=%b lat=%0d exp 0 1", e, lat); end
      do_req(1'b1, 32'h00000010, 2'b10, 1'b1, 32'h0, d, e, lat);
      checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_load got %h exp cafef00d", d); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL l1_latency got %0d exp 1", lat); end
   endtask

   task automatic test_back_to_back;
      int acc[$];
      @(negedge clk);
      aif.req_valid = 1'b1; aif.req_addr = 32'h100; aif.req_size = 2'b10; aif.req_wen = 1'b1;
      aif.resp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (aif.req_ready) acc.push_back(i);
         @(negedge clk);
      end
      aif.req_valid = 1'b0;
      aif.resp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (acc.size() !== 3) begin
         errors++;
         $display("FAIL b2b_count got %0d exp 3", acc.size());
      end else if (acc[1] !== 3 || acc[2] !== 6) begin
         errors++;
         $display("FAIL b2b_spacing got %0d,%0d exp 3,6", acc[1], acc[2]);
      end
      checks++; if (aif.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", aif.req_ready); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      aif.req_valid = 1'b0; aif.req_addr = 32'h0; aif.req_size = 2'b00;
      aif.req_wen = 1'b1; aif.req_wdata = 32'h0; aif.resp_ready = 1'b0;
      bif.req_valid = 1'b0; bif.req_addr = 32'h0; bif.req_size = 2'b00;
      bif.req_wen = 1'b1; bif.req_wdata = 32'h0; bif.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_word_store_load();
      test_partial_merge();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_reset_priority();
      test_latency1_wrap();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
